// File: rtl/rom_stream_reader.sv
// Walks a contiguous ROM address range and streams each word out on a
// valid/ready port with a last-beat marker and a completion pulse.
module rom_stream_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH:0]   remaining, remaining_d;
    logic [ADDR_WIDTH-1:0] rom_addr_d;
    logic [DATA_WIDTH-1:0] m_data_d;
    logic                  m_valid_d;
    logic                  m_last_d;
    logic                  done_d;
    logic                  out_free;

    // Stream handshake: a beat transfers on a rising edge where m_valid & m_ready;
    // once m_valid is raised, m_data/m_last/m_valid hold until that transfer.
    assign out_free  = !m_valid || m_ready;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        rom_addr_d  = rom_addr;
        m_data_d    = m_data;
        m_valid_d   = m_valid;
        m_last_d    = m_last;
        done_d      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rom_addr_d  = start_addr;
                        remaining_d = length;
                        state_d     = READ;
                    end
                end
            end
            READ: begin
                // rom_addr only advances when its word is captured, so a stall
                // keeps the ROM output aligned with the next beat.
                if (out_free) begin
                    m_data_d    = rom_data;
                    m_valid_d   = 1'b1;
                    m_last_d    = (remaining == (ADDR_WIDTH+1)'(1));
                    rom_addr_d  = rom_addr + 1'b1;
                    remaining_d = remaining - 1'b1;
                    if (remaining == (ADDR_WIDTH+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            rom_addr  <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            remaining <= remaining_d;
            rom_addr  <= rom_addr_d;
            m_data    <= m_data_d;
            m_valid   <= m_valid_d;
            m_last    <= m_last_d;
            done      <= done_d;
        end
    end

endmodule
